// File: rtl/rpsc_pkg.sv
// Shared types and default timing constants for the RF power-supply sequencer.
// Status and enable vectors are ordered bit 0 = CA, 1 = G1, 2 = G2, 3 = DR_AMP, 4 = Anode.
package rpsc_pkg;

    localparam int unsigned DEF_WARM_CYC    = 16;
    localparam int unsigned DEF_SETTLE_CYC  = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 32;

    typedef enum logic [3:0] {
        OFF      = 4'd0,
        CA_WARM  = 4'd1,
        G1_UP    = 4'd2,
        G2_UP    = 4'd3,
        DRAMP_UP = 4'd4,
        ANODE_UP = 4'd5,
        RF_ON    = 4'd6,
        SHUTDOWN = 4'd7,
        FAULT    = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        NONE        = 4'd0,
        EXT_FF      = 4'd1,
        TIMEOUT     = 4'd2,
        STATUS_LOST = 4'd3
    } fault_code_t;

    // Statuses already confirmed by earlier steps, whose loss is a fault in this state.
    function automatic logic [4:0] confirmed_mask(input state_t s);
        case (s)
            G1_UP:    return 5'b00001;
            G2_UP:    return 5'b00011;
            DRAMP_UP: return 5'b00111;
            ANODE_UP: return 5'b01111;
            RF_ON:    return 5'b11111;
            default:  return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/rpsc_step_timer.sv
// Settle and timeout counters for one sequencing step.
// A clear pulse makes the counters behave as if they were zeroed on the entry edge.
module rpsc_step_timer
    import rpsc_pkg::*;
#(
    parameter int unsigned WARM_CYC    = DEF_WARM_CYC,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    input  logic warm,
    output logic settle_done,
    output logic timeout_done
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW:0] WARM_LIM   = (CW+1)'(WARM_CYC);
    localparam logic [CW:0] SETTLE_LIM = (CW+1)'(SETTLE_CYC);
    localparam logic [CW:0] TMO_LIM    = (CW+1)'(TIMEOUT_CYC);

    logic [CW-1:0] settle_cnt;
    logic [CW-1:0] tmo_cnt;
    logic [CW:0]   settle_nxt;
    logic [CW:0]   tmo_nxt;
    logic [CW:0]   target;

    // Done flags look one count ahead so the step can advance on the edge the count is reached.
    always_comb begin
        settle_nxt   = (clear ? '0 : {1'b0, settle_cnt}) + (CW+1)'(1);
        tmo_nxt      = (clear ? '0 : {1'b0, tmo_cnt}) + (CW+1)'(1);
        target       = warm ? WARM_LIM : SETTLE_LIM;
        settle_done  = count && (settle_nxt >= target);
        timeout_done = (tmo_nxt >= TMO_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            settle_cnt <= !count ? '0 : ((settle_nxt > TMO_LIM) ? settle_cnt : settle_nxt[CW-1:0]);
            tmo_cnt    <= (tmo_nxt > TMO_LIM) ? tmo_cnt : tmo_nxt[CW-1:0];
        end
    end

endmodule

// File: rtl/rpsc_rf_sequencer.sv
// RF power-supply sequencer: ordered supply start-up, permit/reduce/alarm handling,
// orderly reverse shutdown and first-fault latching.
module rpsc_rf_sequencer
    import rpsc_pkg::*;
#(
    parameter int unsigned WARM_CYC    = DEF_WARM_CYC,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       Not_Reset,
    input  logic       i_Start,
    input  logic       i_Stop,
    input  logic       i_Fault_Clr,
    input  logic       i_Not_CA_ON,
    input  logic       i_Not_G1_OK,
    input  logic       i_Not_G2_OK,
    input  logic       i_Not_DR_AMP_OK,
    input  logic       i_Not_Anode_ON,
    input  logic [4:0] i_FF,
    input  logic       i_Reduce_Req,
    output logic       o_CA_EN,
    output logic       o_G1_EN,
    output logic       o_G2_EN,
    output logic       o_DR_AMP_EN,
    output logic       o_Anode_EN,
    output logic       o_Not_RF_PERM,
    output logic       o_Not_Alarm,
    output logic       o_Not_RF_RED,
    output logic [3:0] o_State,
    output logic [3:0] o_Fault_Code
);

    state_t      state;
    fault_code_t code;
    fault_code_t fault_kind;
    logic [4:0]  en;
    logic [4:0]  status_ok;
    logic        perm_n, alarm_n, red_n;
    logic        timer_clear;
    logic        in_step, own_ok, lost, fault_hit;
    logic        settle_done, timeout_done;

    assign status_ok = ~{i_Not_Anode_ON, i_Not_DR_AMP_OK, i_Not_G2_OK, i_Not_G1_OK, i_Not_CA_ON};

    // SHUTDOWN reuses the settle counter as a free-running drop interval.
    always_comb begin
        in_step = state inside {CA_WARM, G1_UP, G2_UP, DRAMP_UP, ANODE_UP};
        own_ok  = 1'b0;
        case (state)
            CA_WARM:  own_ok = status_ok[0];
            G1_UP:    own_ok = status_ok[1];
            G2_UP:    own_ok = status_ok[2];
            DRAMP_UP: own_ok = status_ok[3];
            ANODE_UP: own_ok = status_ok[4];
            SHUTDOWN: own_ok = 1'b1;
            default:  own_ok = 1'b0;
        endcase
        lost      = |(confirmed_mask(state) & ~status_ok);
        fault_hit = (state != FAULT) && ((|i_FF) || lost || (in_step && timeout_done));
        if (|i_FF)     fault_kind = EXT_FF;
        else if (lost) fault_kind = STATUS_LOST;
        else           fault_kind = TIMEOUT;
    end

    rpsc_step_timer #(
        .WARM_CYC    (WARM_CYC),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (Not_Reset),
        .clear        (timer_clear),
        .count        (own_ok),
        .warm         (state == CA_WARM),
        .settle_done  (settle_done),
        .timeout_done (timeout_done)
    );

    always_ff @(posedge clk or negedge Not_Reset) begin
        if (!Not_Reset) begin
            state       <= OFF;
            code        <= NONE;
            en          <= '0;
            perm_n      <= 1'b1;
            alarm_n     <= 1'b1;
            red_n       <= 1'b1;
            timer_clear <= 1'b0;
        end else begin
            timer_clear <= 1'b0;
            if (fault_hit) begin
                state   <= FAULT;
                code    <= fault_kind;
                en      <= '0;
                perm_n  <= 1'b1;
                alarm_n <= 1'b0;
                red_n   <= 1'b1;
            end else begin
                case (state)
                    OFF: if (i_Start) begin
                        state       <= CA_WARM;
                        en          <= 5'b00001;
                        timer_clear <= 1'b1;
                    end
                    CA_WARM, G1_UP, G2_UP, DRAMP_UP, ANODE_UP: begin
                        if (i_Stop) begin
                            state       <= SHUTDOWN;
                            timer_clear <= 1'b1;
                        end else if (settle_done) begin
                            state       <= state_t'(state + 4'd1);
                            en          <= {en[3:0], 1'b1};
                            timer_clear <= 1'b1;
                            if (state == ANODE_UP) begin
                                perm_n <= 1'b0;
                                red_n  <= !i_Reduce_Req;
                            end
                        end
                    end
                    RF_ON: begin
                        if (i_Stop) begin
                            state       <= SHUTDOWN;
                            perm_n      <= 1'b1;
                            red_n       <= 1'b1;
                            timer_clear <= 1'b1;
                        end else begin
                            red_n <= !i_Reduce_Req;
                        end
                    end
                    // Enables are a contiguous run from CA, so shifting right drops the newest supply.
                    SHUTDOWN: if (settle_done) begin
                        en          <= en >> 1;
                        timer_clear <= 1'b1;
                        if (!en[1]) state <= OFF;
                    end
                    FAULT: if (i_Fault_Clr && !(|i_FF)) begin
                        state   <= OFF;
                        code    <= NONE;
                        alarm_n <= 1'b1;
                    end
                    default: state <= OFF;
                endcase
            end
        end
    end

    assign o_CA_EN       = en[0];
    assign o_G1_EN       = en[1];
    assign o_G2_EN       = en[2];
    assign o_DR_AMP_EN   = en[3];
    assign o_Anode_EN    = en[4];
    assign o_Not_RF_PERM = perm_n;
    assign o_Not_Alarm   = alarm_n;
    assign o_Not_RF_RED  = red_n;
    assign o_State       = state;
    assign o_Fault_Code  = code;

endmodule

// File: tb/tb_rpsc_rf_sequencer.sv
// Self-checking bench: directed sequencing scenarios plus random stimulus against a
// cycle-level behavioural model of the sequencer rules.
module tb_rpsc_rf_sequencer;

    localparam int WARM   = 16;
    localparam int SETTLE = 4;
    localparam int TMO    = 32;

    logic       clk = 1'b0;
    logic       Not_Reset;
    logic       i_Start, i_Stop, i_Fault_Clr, i_Reduce_Req;
    logic [4:0] nstat;
    logic [4:0] i_FF;
    logic       o_CA_EN, o_G1_EN, o_G2_EN, o_DR_AMP_EN, o_Anode_EN;
    logic       o_Not_RF_PERM, o_Not_Alarm, o_Not_RF_RED;
    logic [3:0] o_State, o_Fault_Code;
    logic [4:0] en_vec;

    int checks = 0;
    int errors = 0;

    int m_state, m_code, m_run, m_elapsed, m_on, m_phase;
    bit m_alarm_n, m_red_n;

    always #5 clk = ~clk;

    assign en_vec = {o_Anode_EN, o_DR_AMP_EN, o_G2_EN, o_G1_EN, o_CA_EN};

    rpsc_rf_sequencer #(
        .WARM_CYC    (WARM),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk             (clk),
        .Not_Reset       (Not_Reset),
        .i_Start         (i_Start),
        .i_Stop          (i_Stop),
        .i_Fault_Clr     (i_Fault_Clr),
        .i_Not_CA_ON     (nstat[0]),
        .i_Not_G1_OK     (nstat[1]),
        .i_Not_G2_OK     (nstat[2]),
        .i_Not_DR_AMP_OK (nstat[3]),
        .i_Not_Anode_ON  (nstat[4]),
        .i_FF            (i_FF),
        .i_Reduce_Req    (i_Reduce_Req),
        .o_CA_EN         (o_CA_EN),
        .o_G1_EN         (o_G1_EN),
        .o_G2_EN         (o_G2_EN),
        .o_DR_AMP_EN     (o_DR_AMP_EN),
        .o_Anode_EN      (o_Anode_EN),
        .o_Not_RF_PERM   (o_Not_RF_PERM),
        .o_Not_Alarm     (o_Not_Alarm),
        .o_Not_RF_RED    (o_Not_RF_RED),
        .o_State         (o_State),
        .o_Fault_Code    (o_Fault_Code)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int expEnables();
        int n;
        if (m_state >= 1 && m_state <= 5) n = m_state;
        else if (m_state == 6)            n = 5;
        else if (m_state == 7)            n = m_on;
        else                              n = 0;
        return (1 << n) - 1;
    endfunction

    task automatic compareAll();
        checkOutput("state", o_State, m_state);
        checkOutput("fault_code", o_Fault_Code, m_code);
        checkOutput("enables", en_vec, expEnables());
        checkOutput("not_rf_perm", o_Not_RF_PERM, (m_state == 6) ? 0 : 1);
        checkOutput("not_alarm", o_Not_Alarm, m_alarm_n);
        checkOutput("not_rf_red", o_Not_RF_RED, m_red_n);
    endtask

    task automatic modelReset();
        m_state = 0; m_code = 0; m_run = 0; m_elapsed = 0; m_on = 0; m_phase = 0;
        m_alarm_n = 1'b1; m_red_n = 1'b1;
    endtask

    task automatic enterFault(input int c);
        m_state   = 8;
        m_code    = c;
        m_alarm_n = 1'b0;
    endtask

    // One rising edge of the sequencing rules, applied to the inputs currently driven.
    task automatic modelStep();
        bit ok [5];
        bit lost;
        for (int i = 0; i < 5; i++) ok[i] = (nstat[i] == 1'b0);
        if (m_state != 8 && i_FF != 0) begin
            enterFault(1);
        end else if (m_state == 0) begin
            if (i_Start) begin m_state = 1; m_run = 0; m_elapsed = 0; end
        end else if (m_state == 8) begin
            if (i_Fault_Clr && i_FF == 0) begin m_state = 0; m_code = 0; m_alarm_n = 1'b1; end
        end else if (m_state <= 6) begin
            lost = 1'b0;
            for (int j = 0; j < m_state - 1; j++) if (!ok[j]) lost = 1'b1;
            if (lost) enterFault(3);
            else if (m_state <= 5 && m_elapsed + 1 >= TMO) enterFault(2);
            else if (i_Stop) begin
                m_on = (m_state <= 5) ? m_state : 5;
                m_state = 7;
                m_phase = 0;
            end else if (m_state <= 5) begin
                m_elapsed++;
                if (ok[m_state-1]) begin
                    m_run++;
                    if (m_run >= ((m_state == 1) ? WARM : SETTLE)) begin
                        m_state++; m_run = 0; m_elapsed = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end else begin
            m_phase++;
            if (m_phase == SETTLE) begin
                m_on--; m_phase = 0;
                if (m_on == 0) m_state = 0;
            end
        end
        m_red_n = !(m_state == 6 && i_Reduce_Req);
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, compare at the next falling edge.
    task automatic applyStimulus(input bit start, input bit stop, input bit clr,
                                 input logic [4:0] ns, input logic [4:0] ff, input bit reduce);
        i_Start = start; i_Stop = stop; i_Fault_Clr = clr;
        nstat = ns; i_FF = ff; i_Reduce_Req = reduce;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    task automatic waitState(input int target, input logic [4:0] ns, input string tag, output int n);
        n = 0;
        while (o_State != target && n < 200) begin
            applyStimulus(0, 0, 0, ns, 5'b0, 0);
            n++;
        end
        checkOutput(tag, o_State, target);
    endtask

    task automatic doReset();
        #2 Not_Reset = 1'b0;
        #1 modelReset();
        checkOutput("async_rst_enables", en_vec, 0);
        checkOutput("async_rst_state", o_State, 0);
        compareAll();
        @(negedge clk);
        Not_Reset = 1'b1;
    endtask

    initial begin
        int n;
        bit noisy;
        logic [4:0] ns;
        logic [4:0] ff;

        Not_Reset = 1'b0;
        i_Start = 0; i_Stop = 0; i_Fault_Clr = 0; i_Reduce_Req = 0;
        nstat = '0; i_FF = '0;
        modelReset();
        repeat (2) @(negedge clk);
        compareAll();
        checkOutput("reset_alarm", o_Not_Alarm, 1);
        Not_Reset = 1'b1;

        // Full start-up with all statuses OK.
        applyStimulus(1, 0, 0, 5'b0, 5'b0, 0);
        checkOutput("ca_warm_edge1", o_State, 1);
        n = 1;
        while (o_State != 6 && n < 100) begin
            applyStimulus(0, 0, 0, 5'b0, 5'b0, 0);
            n++;
        end
        checkOutput("rf_on_edge", n, 1 + WARM + 4 * SETTLE);
        checkOutput("perm_in_rf_on", o_Not_RF_PERM, 0);

        // Reduce request, then loss of an already-confirmed status.
        applyStimulus(0, 0, 0, 5'b0, 5'b0, 1);
        checkOutput("reduce_low", o_Not_RF_RED, 0);
        applyStimulus(0, 0, 0, 5'b00010, 5'b0, 1);
        checkOutput("lost_state", o_State, 8);
        checkOutput("lost_code", o_Fault_Code, 3);
        applyStimulus(0, 0, 1, 5'b0, 5'b0, 0);
        checkOutput("clr_state", o_State, 0);

        // G2 never settles: timeout from G2_UP entry.
        applyStimulus(1, 0, 0, 5'b00100, 5'b0, 0);
        waitState(3, 5'b00100, "reach_g2_up", n);
        n = 0;
        while (o_State != 8 && n < 100) begin
            applyStimulus(0, 0, 0, 5'b00100, 5'b0, 0);
            n++;
        end
        checkOutput("timeout_cycles", n, TMO);
        checkOutput("timeout_code", o_Fault_Code, 2);
        checkOutput("timeout_enables", en_vec, 0);
        checkOutput("timeout_alarm", o_Not_Alarm, 0);
        applyStimulus(0, 0, 1, 5'b0, 5'b0, 0);

        // External fault with a simultaneous stop: fault wins.
        applyStimulus(1, 0, 0, 5'b0, 5'b0, 0);
        waitState(6, 5'b0, "reach_rf_on_ff", n);
        applyStimulus(0, 1, 0, 5'b0, 5'b00100, 0);
        checkOutput("ff_state", o_State, 8);
        checkOutput("ff_code", o_Fault_Code, 1);
        applyStimulus(0, 0, 1, 5'b0, 5'b0, 0);
        checkOutput("ff_clr_state", o_State, 0);
        checkOutput("ff_clr_code", o_Fault_Code, 0);

        // Orderly shutdown from RF_ON.
        applyStimulus(1, 0, 0, 5'b0, 5'b0, 0);
        waitState(6, 5'b0, "reach_rf_on_stop", n);
        applyStimulus(0, 1, 0, 5'b0, 5'b0, 0);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(0, 0, 0, 5'b0, 5'b0, 0);
            checkOutput("shutdown_enables", en_vec, 31 >> (k / SETTLE));
        end
        checkOutput("shutdown_off", o_State, 0);
        checkOutput("shutdown_code", o_Fault_Code, 0);

        // Asynchronous reset in DRAMP_UP.
        applyStimulus(1, 0, 0, 5'b0, 5'b0, 0);
        waitState(4, 5'b0, "reach_dramp_up", n);
        doReset();

        // Randomized operation against the model.
        noisy = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            if (it % 64 == 0) noisy = ($urandom_range(0, 3) == 0);
            ns = '0;
            if (noisy) for (int b = 0; b < 5; b++) ns[b] = ($urandom_range(0, 15) == 0);
            ff = ($urandom_range(0, 299) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
            if ($urandom_range(0, 799) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                              $urandom_range(0, 3) == 0, ns, ff, 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
